// File: rtl/ulpi_pkg.sv
// Shared encodings for the ULPI link: FSM states, command prefixes, register map, RX event codes.
// ULPI_LINK_REG_PORT_EN adds the register-read states.
package ulpi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_DATA,
        ST_REG_CMD,
        ST_REG_DATA,
        ST_REG_STP
`ifdef ULPI_LINK_REG_PORT_EN
        ,
        ST_RD_CMD,
        ST_RD_TURN,
        ST_RD_DATA
`endif
    } ulpi_state_e;

    localparam logic [1:0] CMD_TX     = 2'b01;
    localparam logic [1:0] CMD_REG_WR = 2'b10;
    localparam logic [1:0] CMD_REG_RD = 2'b11;

    localparam logic [5:0] FUNC_CTRL  = 6'h04;

    localparam logic [1:0] RXEV_INACTIVE = 2'b00;
    localparam logic [1:0] RXEV_ACTIVE   = 2'b01;
    localparam logic [1:0] RXEV_HOSTDISC = 2'b10;
    localparam logic [1:0] RXEV_ERROR    = 2'b11;

    // Register transaction latched at the IDLE decision.
    typedef struct packed {
        logic [7:0] cmd;
        logic [7:0] wdata;
        logic       func;
    } ulpi_wr_t;

endpackage

// File: rtl/ulpi_link_rx.sv
// Registered decoder for RX CMD and RX data bytes received while the PHY owns the bus.
module ulpi_link_rx
    import ulpi_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic       dir_q_i,
    input  logic       nxt_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       rxvalid_o,
    output logic       rxactive_o,
    output logic       rxerror_o,
    output logic [1:0] linestate_o
);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_o      <= '0;
            rxvalid_o   <= 1'b0;
            rxactive_o  <= 1'b0;
            rxerror_o   <= 1'b0;
            linestate_o <= '0;
        end else begin
            rxvalid_o <= 1'b0;
            if (dir_q_i && !dir_i) begin
                rxactive_o <= 1'b0;
                rxerror_o  <= 1'b0;
            end else if (en_i && dir_i && dir_q_i) begin
                if (nxt_i) begin
                    data_o    <= data_i;
                    rxvalid_o <= 1'b1;
                end else begin
                    linestate_o <= data_i[1:0];
                    case (data_i[5:4])
                        RXEV_ACTIVE: begin
                            rxactive_o <= 1'b1;
                            rxerror_o  <= 1'b0;
                        end
                        RXEV_ERROR: begin
                            rxactive_o <= 1'b1;
                            rxerror_o  <= 1'b1;
                        end
                        default: begin
                            rxactive_o <= 1'b0;
                            rxerror_o  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: rtl/ulpi_link.sv
// Link-side ULPI bridge: UTMI+ level-0 TX/RX plus automatic Function Control writes.
// ULPI_LINK_REG_PORT_EN adds a generic register read/write port.
module ulpi_link
    import ulpi_pkg::*;
#(
    parameter logic [7:0] FUNC_CTRL_RST = 8'h41
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] ulpi_data_i,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic [7:0] ulpi_data_o,
    output logic       ulpi_stp_o,
    input  logic [7:0] utmi_data_i,
    input  logic       utmi_txvalid_i,
    output logic       utmi_txready_o,
    output logic [7:0] utmi_data_o,
    output logic       utmi_rxvalid_o,
    output logic       utmi_rxactive_o,
    output logic       utmi_rxerror_o,
    output logic [1:0] utmi_linestate_o,
    input  logic [1:0] utmi_xcvrselect_i,
    input  logic       utmi_termselect_i,
    input  logic [1:0] utmi_opmode_i,
    input  logic       utmi_reset_i
`ifdef ULPI_LINK_REG_PORT_EN
    ,
    input  logic       reg_req_i,
    input  logic       reg_we_i,
    input  logic [5:0] reg_addr_i,
    input  logic [7:0] reg_wdata_i,
    output logic       reg_ack_o,
    output logic [7:0] reg_rdata_o
`endif
);

    ulpi_state_e state_q, state_d;
    ulpi_wr_t    wr_q, wr_d;
    logic [7:0]  func_q;
    logic        dir_q, turn, dir_rise;
    logic        tx_block_q, tx_block_d;
    logic        func_done, rd_state;
    logic [7:0]  data_c;
    logic        stp_c, txready_c;
    logic [7:0]  func_want;

    assign turn      = dir_q != ulpi_dir_i;
    assign dir_rise  = ulpi_dir_i && !dir_q;
    assign func_want = {2'b01, utmi_reset_i, utmi_opmode_i, utmi_termselect_i, utmi_xcvrselect_i};

`ifdef ULPI_LINK_REG_PORT_EN
    logic       ack_d;
    logic [7:0] rdata_d;
    assign rd_state = (state_q == ST_RD_CMD) || (state_q == ST_RD_TURN) || (state_q == ST_RD_DATA);
`else
    assign rd_state = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_d       = wr_q;
        tx_block_d = tx_block_q;
        data_c     = '0;
        stp_c      = 1'b0;
        txready_c  = 1'b0;
        func_done  = 1'b0;
`ifdef ULPI_LINK_REG_PORT_EN
        ack_d      = 1'b0;
        rdata_d    = reg_rdata_o;
`endif
        if (!utmi_txvalid_i) tx_block_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!ulpi_dir_i && !turn) begin
                    if (func_q != func_want) begin
                        wr_d    = '{cmd: {CMD_REG_WR, FUNC_CTRL}, wdata: func_want, func: 1'b1};
                        state_d = ST_REG_CMD;
                    end
`ifdef ULPI_LINK_REG_PORT_EN
                    // Ack is still high while the requester sees it; don't restart on the stale req.
                    else if (reg_req_i && !reg_ack_o) begin
                        wr_d    = '{cmd: {reg_we_i ? CMD_REG_WR : CMD_REG_RD, reg_addr_i},
                                    wdata: reg_wdata_i, func: 1'b0};
                        state_d = reg_we_i ? ST_REG_CMD : ST_RD_CMD;
                    end
`endif
                    else if (utmi_txvalid_i && !tx_block_q) begin
                        state_d = ST_TX_CMD;
                    end
                end
            end
            ST_TX_CMD: begin
                data_c    = {CMD_TX, 2'b00, utmi_data_i[3:0]};
                txready_c = ulpi_nxt_i;
                if (ulpi_nxt_i) state_d = ST_TX_DATA;
            end
            ST_TX_DATA: begin
                if (!utmi_txvalid_i) begin
                    stp_c   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    data_c    = utmi_data_i;
                    txready_c = ulpi_nxt_i;
                end
            end
            ST_REG_CMD: begin
                data_c = wr_q.cmd;
                if (ulpi_nxt_i) state_d = ST_REG_DATA;
            end
            ST_REG_DATA: begin
                data_c = wr_q.wdata;
                if (ulpi_nxt_i) state_d = ST_REG_STP;
            end
            ST_REG_STP: begin
                stp_c     = 1'b1;
                state_d   = ST_IDLE;
                func_done = wr_q.func && !ulpi_dir_i;
`ifdef ULPI_LINK_REG_PORT_EN
                ack_d     = !wr_q.func && !ulpi_dir_i;
`endif
            end
`ifdef ULPI_LINK_REG_PORT_EN
            ST_RD_CMD: begin
                data_c = wr_q.cmd;
                if (ulpi_nxt_i || ulpi_dir_i) state_d = ST_RD_TURN;
            end
            ST_RD_TURN, ST_RD_DATA: begin
                if (ulpi_dir_i && dir_q) begin
                    rdata_d = ulpi_data_i;
                    ack_d   = 1'b1;
                    state_d = ST_IDLE;
                end else if (dir_rise) begin
                    state_d = ST_RD_DATA;
                end else if (state_q == ST_RD_DATA && !ulpi_dir_i) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // PHY grabbing the bus aborts a link transfer; an interrupted packet must not restart.
        if (dir_rise && state_q != ST_IDLE && !rd_state) begin
            state_d = ST_IDLE;
            if (state_q == ST_TX_CMD || state_q == ST_TX_DATA) tx_block_d = 1'b1;
        end else if (turn && !rd_state) begin
            state_d = state_q;
        end
    end

    assign ulpi_data_o    = (ulpi_dir_i || turn) ? 8'h00 : data_c;
    assign ulpi_stp_o     = ulpi_dir_i ? 1'b0 : stp_c;
    assign utmi_txready_o = ulpi_dir_i ? 1'b0 : txready_c;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            dir_q      <= 1'b0;
            func_q     <= FUNC_CTRL_RST;
            tx_block_q <= 1'b0;
            wr_q       <= '0;
        end else begin
            state_q    <= state_d;
            dir_q      <= ulpi_dir_i;
            tx_block_q <= tx_block_d;
            wr_q       <= wr_d;
            if (func_done) func_q <= wr_q.wdata;
        end
    end

`ifdef ULPI_LINK_REG_PORT_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            reg_ack_o   <= 1'b0;
            reg_rdata_o <= '0;
        end else begin
            reg_ack_o   <= ack_d;
            reg_rdata_o <= rdata_d;
        end
    end
`endif

    ulpi_link_rx u_rx (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .en_i        (!rd_state),
        .dir_i       (ulpi_dir_i),
        .dir_q_i     (dir_q),
        .nxt_i       (ulpi_nxt_i),
        .data_i      (ulpi_data_i),
        .data_o      (utmi_data_o),
        .rxvalid_o   (utmi_rxvalid_o),
        .rxactive_o  (utmi_rxactive_o),
        .rxerror_o   (utmi_rxerror_o),
        .linestate_o (utmi_linestate_o)
    );

endmodule

// File: doc/ulpi_link.md
# ulpi_link

Link-side ULPI interface: converts a UTMI+ level-0 controller interface into ULPI signalling toward an external (or modelled) ULPI PHY. Sits directly upstream of the PHY:
- drives TX commands, TX data and register writes on `ulpi_data_o`/`ulpi_stp_o`;
- decodes RX CMD and RX data bytes received while the PHY owns the bus (`ulpi_dir_i`=1).

## Interface
Parameters:
- `FUNC_CTRL_RST`, 8'h41: reset value of the Function Control shadow; must match the PHY power-on value.

Ports:
- `clk_i` in 1: ULPI 60 MHz clock; all logic on the rising edge.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `ulpi_data_i` in 8: bus from PHY.
- `ulpi_dir_i` in 1: PHY owns bus.
- `ulpi_nxt_i` in 1: PHY throttle/accept.
- `ulpi_data_o` out 8: bus to PHY.
- `ulpi_stp_o` out 1: end of link transfer.
- `utmi_data_i` in 8: TX byte (first byte = PID).
- `utmi_txvalid_i` in 1: TX packet active.
- `utmi_txready_o` out 1: current TX byte accepted.
- `utmi_data_o` out 8: RX byte.
- `utmi_rxvalid_o` out 1: RX byte valid.
- `utmi_rxactive_o` out 1: RX packet active.
- `utmi_rxerror_o` out 1: RX error.
- `utmi_linestate_o` out 2: line state.
- `utmi_xcvrselect_i` in 2: Function Control field.
- `utmi_termselect_i` in 1: Function Control field.
- `utmi_opmode_i` in 2: Function Control field.
- `utmi_reset_i` in 1: Function Control field.

## Operation
- Turnaround: `dir_q` registers `ulpi_dir_i`. A cycle with `dir_q != ulpi_dir_i` is turnaround:
  - `ulpi_data_i` ignored;
  - `ulpi_data_o`=0;
  - state_q frozen, except for the abort transitions below.
- States: IDLE, TX_CMD, TX_DATA, REG_CMD, REG_DATA, REG_STP. Plus RD_CMD, RD_TURN, RD_DATA with macro.
- IDLE arbitration (only when `ulpi_dir_i`=0 and not turnaround). Priority, highest first:
  1. Function Control write: pending when `func_q[5:0]` != {reset,opmode,termselect,xcvrselect}.
  2. Register port request (macro).
  3. TX: `utmi_txvalid_i`=1 and `tx_block_q`=0.
- Function Control write:
  - REG_CMD: drive 8'h84 until `nxt`=1.
  - REG_DATA: drive {1'b0,1'b1,reset,opmode,termselect,xcvrselect} until `nxt`=1.
  - REG_STP: `stp`=1, data 0, one cycle; `func_q` updates on REG_STP exit; -> IDLE.
- TX:
  - TX_CMD: drive {2'b01,2'b00,`utmi_data_i[3:0]`}.
  - `nxt`=1 in TX_CMD -> `utmi_txready_o`=1 (PID consumed) -> TX_DATA.
  - TX_DATA: drive `utmi_data_i`; `utmi_txready_o`=`nxt`.
  - `utmi_txvalid_i`=0 in TX_DATA -> `stp`=1, data 0 that cycle -> IDLE.
- RX: when `ulpi_dir_i`=1 and `dir_q`=1:
  - `nxt`=1: `utmi_data_o`<=`ulpi_data_i`, `utmi_rxvalid_o`<=1.
  - `nxt`=0 (RX CMD): `linestate`<=`data[1:0]`; `data[5:4]` 00/10 -> rxactive 0, rxerror 0; 01 -> rxactive 1, rxerror 0; 11 -> rxactive 1, rxerror 1.
  - `dir` falling: `rxactive`<=0, `rxerror`<=0.
- Abort: `ulpi_dir_i` rising in any non-IDLE state -> IDLE.
  - `func_q` not updated; the write retries after `dir` returns.
  - TX abort sets `tx_block_q`; it clears when `utmi_txvalid_i`=0, so no partial packet is restarted.

## Timing
- Reset: every output 0. `func_q`=`FUNC_CTRL_RST`, state IDLE, `tx_block_q`=0. Async reset mid-transfer returns to IDLE with no stp.
- `ulpi_data_o`, `ulpi_stp_o`, `utmi_txready_o` are combinational from state_q, `ulpi_nxt_i`, `ulpi_dir_i`, `utmi_*` inputs. They are forced 0 whenever `ulpi_dir_i`=1.
- UTMI RX outputs are registered: one-cycle latency from the `ulpi_data_i` sample. `utmi_rxvalid_o` is a single-cycle pulse per byte.
- First TX command byte is driven the cycle after the IDLE decision. Zero-wait PHY: a Function Control write takes 3 cycles, REG_CMD to REG_STP.

## Configuration
- `ULPI_LINK_REG_PORT_EN` defined: adds register-access ports:
  - `reg_req_i` in 1, `reg_we_i` in 1, `reg_addr_i` in 6, `reg_wdata_i` in 8;
  - `reg_ack_o` out 1, `reg_rdata_o` out 8.
- Write (`reg_we_i`=1): same sequence as the Function Control write, with command {2'b10,addr}.
- Read (`reg_we_i`=0):
  - RD_CMD: drive {2'b11,addr} until `nxt` or `dir`=1.
  - RD_TURN: wait for turnaround.
  - RD_DATA: capture `ulpi_data_i` when `dir_q`=`dir`=1.
  - `reg_ack_o` 1-cycle pulse; then IDLE.
- Not defined: those ports and states are absent; only automatic Function Control writes exist.

## Structure
- Package `ulpi_pkg`:
  - state encoding;
  - command prefixes CMD_TX 2'b01, CMD_REG_WR 2'b10, CMD_REG_RD 2'b11;
  - register address FUNC_CTRL 6'h04;
  - RX event codes.
- Sub-module `ulpi_link_rx`: the registered RX CMD/RX data decoder.

## Test plan
- Reset, `utmi_opmode_i`=2'b01 -> bus 8'h84, then 8'h49, then `stp`=1; no further write once equal.
- TX of PID 8'hC3 + 8'h11,8'h22 with PHY `nxt` stalled 2 cycles -> bus 8'h43,8'h11,8'h22. `stp` goes high for 1 cycle after the last byte. `utmi_txready_o` pulses 3 times.
- PHY `dir`=1, RX CMD 8'h11, data 8'hA5 (`nxt`=1), RX CMD 8'h01, `dir`=0 -> rxactive rises, rxvalid pulses with 8'hA5, rxactive falls, linestate=01.
- `dir` rises during TX_DATA with txvalid held -> no stp, bus 0. No new TX_CMD until txvalid drops and rises again.
- RX CMD with event 11 -> `utmi_rxerror_o`=1 one cycle later.
- With `ULPI_LINK_REG_PORT_EN`: read addr 6'h16 after writing 8'h5A -> `reg_rdata_o`=8'h5A with `reg_ack_o` pulse.
